// File: rtl/rf_pkg.sv
`default_nettype none
// ============================================================================
// Module      : rf_pkg
// Description : Shared constants and source-readiness helper for reg_file_mp.
// Revision    : 1.0 - initial release
// ============================================================================
package rf_pkg;

    localparam int c_dwidth_default = 16;
    localparam int c_nregs_default  = 4;
    localparam int c_max_awidth     = 16;

    // Callers zero-extend addresses to c_max_awidth so one helper serves any depth.
    function automatic logic src_readable(
        input logic                    busy_bit,
        input logic                    wr_en,
        input logic [c_max_awidth-1:0] wr_addr,
        input logic [c_max_awidth-1:0] src_addr
    );
        return !busy_bit || (wr_en && (wr_addr == src_addr));
    endfunction

endpackage
`default_nettype wire

// File: rtl/rf_scoreboard.sv
`default_nettype none
// ============================================================================
// Module      : rf_scoreboard
// Description : Per-register pending-write bits; lock sets, write clears,
//               set wins on collision, r0 optionally pinned to zero.
// Revision    : 1.0 - initial release
// ============================================================================
module rf_scoreboard #(
    parameter int NREGS   = 4,
    parameter int AWIDTH  = $clog2(NREGS),
    parameter int ZERO_R0 = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wr_en,
    input  logic [AWIDTH-1:0] wr_addr,
    input  logic              lock_en,
    input  logic [AWIDTH-1:0] lock_addr,
    output logic [NREGS-1:0]  busy
);

    logic [NREGS-1:0] w_set;
    logic [NREGS-1:0] w_clr;
    logic [NREGS-1:0] r_busy;

    for (genvar i = 0; i < NREGS; i++) begin : g_dec
        if ((ZERO_R0 != 0) && (i == 0)) begin : g_zero
            assign w_set[i] = 1'b0;
            assign w_clr[i] = 1'b0;
        end else begin : g_norm
            assign w_set[i] = lock_en && (lock_addr == AWIDTH'(i));
            assign w_clr[i] = wr_en   && (wr_addr   == AWIDTH'(i));
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_busy <= '0;
        end else begin
            for (int i = 0; i < NREGS; i++) begin
                if (w_set[i]) begin
                    r_busy[i] <= 1'b1;
                end else if (w_clr[i]) begin
                    r_busy[i] <= 1'b0;
                end
            end
        end
    end

    assign busy = r_busy;

endmodule
`default_nettype wire

// File: rtl/reg_file_mp.sv
`default_nettype none
// ============================================================================
// Module      : reg_file_mp
// Description : Register file, one write port, two registered read ports with
//               write bypass and a pending-write scoreboard stalling reads.
// Revision    : 1.0 - initial release
// ============================================================================
module reg_file_mp
    import rf_pkg::*;
#(
    parameter int DWIDTH  = c_dwidth_default,
    parameter int NREGS   = c_nregs_default,
    parameter int AWIDTH  = $clog2(NREGS),
    parameter int ZERO_R0 = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wr_en,
    input  logic [AWIDTH-1:0] wr_addr,
    input  logic [DWIDTH-1:0] wr_data,
    input  logic              lock_en,
    input  logic [AWIDTH-1:0] lock_addr,
    input  logic              rd_req,
    input  logic [AWIDTH-1:0] rd_addr,
    input  logic [AWIDTH-1:0] rs_addr,
    output logic              rd_ready,
    output logic [DWIDTH-1:0] rd_q,
    output logic [DWIDTH-1:0] rs_q,
    output logic              en_out,
    output logic [NREGS-1:0]  busy
);

    logic [DWIDTH-1:0] r_mem [NREGS];
    logic [NREGS-1:0]  w_wr_hit;
    logic              w_rd_ok;
    logic              w_rs_ok;
    logic              w_accept;
    logic [DWIDTH-1:0] w_rd_val;
    logic [DWIDTH-1:0] w_rs_val;

    rf_scoreboard #(
        .NREGS   (NREGS),
        .AWIDTH  (AWIDTH),
        .ZERO_R0 (ZERO_R0)
    ) u_scoreboard (
        .clk       (clk),
        .rst       (rst),
        .wr_en     (wr_en),
        .wr_addr   (wr_addr),
        .lock_en   (lock_en),
        .lock_addr (lock_addr),
        .busy      (busy)
    );

    for (genvar i = 0; i < NREGS; i++) begin : g_wr_dec
        if ((ZERO_R0 != 0) && (i == 0)) begin : g_zero
            assign w_wr_hit[i] = 1'b0;
        end else begin : g_norm
            assign w_wr_hit[i] = wr_en && (wr_addr == AWIDTH'(i));
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NREGS; i++) begin
                r_mem[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NREGS; i++) begin
                if (w_wr_hit[i]) begin
                    r_mem[i] <= wr_data;
                end
            end
        end
    end

    assign w_rd_ok  = src_readable(busy[rd_addr], wr_en,
                                   c_max_awidth'(wr_addr), c_max_awidth'(rd_addr));
    assign w_rs_ok  = src_readable(busy[rs_addr], wr_en,
                                   c_max_awidth'(wr_addr), c_max_awidth'(rs_addr));
    assign rd_ready = w_rd_ok && w_rs_ok;
    assign w_accept = rd_req && rd_ready;

    // The r0 zero rule is applied last so it overrides any bypass.
    always_comb begin
        w_rd_val = r_mem[rd_addr];
        if (wr_en && (wr_addr == rd_addr)) begin
            w_rd_val = wr_data;
        end
        if ((ZERO_R0 != 0) && (rd_addr == '0)) begin
            w_rd_val = '0;
        end
        w_rs_val = r_mem[rs_addr];
        if (wr_en && (wr_addr == rs_addr)) begin
            w_rs_val = wr_data;
        end
        if ((ZERO_R0 != 0) && (rs_addr == '0)) begin
            w_rs_val = '0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_q   <= '0;
            rs_q   <= '0;
            en_out <= 1'b0;
        end else begin
            en_out <= w_accept;
            if (w_accept) begin
                rd_q <= w_rd_val;
                rs_q <= w_rs_val;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_reg_file_mp.sv
`default_nettype none
// ============================================================================
// Module      : tb_reg_file_mp
// Description : Scoreboard bench for reg_file_mp: default 16x4 instance and a
//               32x16 instance with r0 hard-wired to zero.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_reg_file_mp;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    logic        a_wr_en = 1'b0, a_lock_en = 1'b0, a_rd_req = 1'b0;
    logic [1:0]  a_wr_addr = '0, a_lock_addr = '0, a_rd_addr = '0, a_rs_addr = '0;
    logic [15:0] a_wr_data = '0;
    logic        a_rd_ready, a_en_out;
    logic [15:0] a_rd_q, a_rs_q;
    logic [3:0]  a_busy;

    logic        b_wr_en = 1'b0, b_lock_en = 1'b0, b_rd_req = 1'b0;
    logic [3:0]  b_wr_addr = '0, b_lock_addr = '0, b_rd_addr = '0, b_rs_addr = '0;
    logic [31:0] b_wr_data = '0;
    logic        b_rd_ready, b_en_out;
    logic [31:0] b_rd_q, b_rs_q;
    logic [15:0] b_busy;

    logic [31:0] a_exp_q [$];
    logic [63:0] b_exp_q [$];

    reg_file_mp u_dut_a (
        .clk(clk), .rst(rst),
        .wr_en(a_wr_en), .wr_addr(a_wr_addr), .wr_data(a_wr_data),
        .lock_en(a_lock_en), .lock_addr(a_lock_addr),
        .rd_req(a_rd_req), .rd_addr(a_rd_addr), .rs_addr(a_rs_addr),
        .rd_ready(a_rd_ready), .rd_q(a_rd_q), .rs_q(a_rs_q),
        .en_out(a_en_out), .busy(a_busy)
    );

    reg_file_mp #(.DWIDTH(32), .NREGS(16), .ZERO_R0(1)) u_dut_b (
        .clk(clk), .rst(rst),
        .wr_en(b_wr_en), .wr_addr(b_wr_addr), .wr_data(b_wr_data),
        .lock_en(b_lock_en), .lock_addr(b_lock_addr),
        .rd_req(b_rd_req), .rd_addr(b_rd_addr), .rs_addr(b_rs_addr),
        .rd_ready(b_rd_ready), .rd_q(b_rd_q), .rs_q(b_rs_q),
        .en_out(b_en_out), .busy(b_busy)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
        end
    endtask

    task automatic a_drive(input int we, input int wa, input int wd, input int le,
                           input int la, input int rq, input int ra, input int sa);
        @(posedge clk);
        #1;
        a_wr_en   = 1'(we);  a_wr_addr   = 2'(wa); a_wr_data = 16'(wd);
        a_lock_en = 1'(le);  a_lock_addr = 2'(la);
        a_rd_req  = 1'(rq);  a_rd_addr   = 2'(ra); a_rs_addr = 2'(sa);
    endtask

    task automatic b_drive(input int we, input int wa, input int wd, input int le,
                           input int la, input int rq, input int ra, input int sa);
        @(posedge clk);
        #1;
        b_wr_en   = 1'(we);  b_wr_addr   = 4'(wa); b_wr_data = 32'(wd);
        b_lock_en = 1'(le);  b_lock_addr = 4'(la);
        b_rd_req  = 1'(rq);  b_rd_addr   = 4'(ra); b_rs_addr = 4'(sa);
    endtask

    // Monitors: every en_out pulse must match the oldest queued expectation.
    always @(negedge clk) begin
        logic [31:0] e;
        if (a_en_out) begin
            if (a_exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL a_unexpected_en_out: got rd_q=0x%0h rs_q=0x%0h, required no pulse",
                         a_rd_q, a_rs_q);
            end else begin
                e = a_exp_q.pop_front();
                check("a_rd_q", 64'(a_rd_q), 64'(e[31:16]));
                check("a_rs_q", 64'(a_rs_q), 64'(e[15:0]));
            end
        end
    end

    always @(negedge clk) begin
        logic [63:0] e;
        if (b_en_out) begin
            if (b_exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL b_unexpected_en_out: got rd_q=0x%0h rs_q=0x%0h, required no pulse",
                         b_rd_q, b_rs_q);
            end else begin
                e = b_exp_q.pop_front();
                check("b_rd_q", 64'(b_rd_q), 64'(e[63:32]));
                check("b_rs_q", 64'(b_rs_q), 64'(e[31:0]));
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not complete, required completion");
        $fatal(1, "timeout");
    end

    initial begin
        // Reset state
        repeat (3) @(negedge clk);
        check("a_rst_rd_q",   64'(a_rd_q),   64'h0);
        check("a_rst_rs_q",   64'(a_rs_q),   64'h0);
        check("a_rst_en_out", 64'(a_en_out), 64'h0);
        check("a_rst_busy",   64'(a_busy),   64'h0);
        check("b_rst_busy",   64'(b_busy),   64'h0);
        check("b_rst_en_out", 64'(b_en_out), 64'h0);
        @(posedge clk);
        #1 rst = 1'b0;

        for (int k = 0; k < 4; k++) begin
            a_drive(0, 0, 0, 0, 0, 1, k, k);
            a_exp_q.push_back(32'h0);
        end
        a_drive(0, 0, 0, 0, 0, 0, 0, 0);

        // Basic write then read
        a_drive(1, 2, 'h1234, 0, 0, 0, 0, 0);
        a_drive(1, 3, 'hBEEF, 0, 0, 0, 0, 0);
        a_drive(0, 0, 0, 0, 0, 1, 2, 3);
        a_exp_q.push_back({16'h1234, 16'hBEEF});
        a_drive(0, 0, 0, 0, 0, 0, 0, 0);

        // Stall on busy r1, released by a bypassed write
        a_drive(0, 0, 0, 1, 1, 0, 0, 0);
        a_drive(0, 0, 0, 0, 0, 1, 2, 1);
        @(negedge clk);
        check("a_stall_ready", 64'(a_rd_ready), 64'h0);
        check("a_stall_busy",  64'(a_busy),     64'h2);
        a_drive(0, 0, 0, 0, 0, 1, 2, 1);
        @(negedge clk);
        check("a_stall_ready2", 64'(a_rd_ready), 64'h0);
        check("a_stall_en_out", 64'(a_en_out),   64'h0);
        a_drive(1, 1, 'h00AA, 0, 0, 1, 2, 1);
        a_exp_q.push_back({16'h1234, 16'h00AA});
        @(negedge clk);
        check("a_bypass_ready", 64'(a_rd_ready), 64'h1);
        a_drive(0, 0, 0, 0, 0, 0, 0, 0);
        @(negedge clk);
        check("a_busy1_cleared", 64'(a_busy), 64'h0);

        // Lock and write on r2 in the same cycle: lock wins
        a_drive(1, 2, 'h5555, 1, 2, 0, 0, 0);
        a_drive(0, 0, 0, 0, 0, 1, 2, 0);
        @(negedge clk);
        check("a_collide_busy",  64'(a_busy),     64'h4);
        check("a_collide_ready", 64'(a_rd_ready), 64'h0);
        a_drive(1, 2, 'h7777, 0, 0, 1, 2, 0);
        a_exp_q.push_back({16'h7777, 16'h0000});
        @(negedge clk);
        check("a_r2_bypass_ready", 64'(a_rd_ready), 64'h1);

        // Lock in the accept cycle does not stall that read
        a_drive(0, 0, 0, 1, 3, 1, 3, 3);
        a_exp_q.push_back({16'hBEEF, 16'hBEEF});
        @(negedge clk);
        check("a_lock_accept_ready", 64'(a_rd_ready), 64'h1);
        a_drive(0, 0, 0, 0, 0, 1, 2, 1);
        a_exp_q.push_back({16'h7777, 16'h00AA});
        @(negedge clk);
        check("a_busy3_set", 64'(a_busy), 64'h8);

        // Reset asserted while a result is being presented
        a_drive(0, 0, 0, 0, 0, 1, 2, 1);
        @(posedge clk);
        #1;
        check("a_en_before_rst", 64'(a_en_out), 64'h1);
        a_rd_req = 1'b0;
        rst = 1'b1;
        #1;
        check("a_midrst_en_out", 64'(a_en_out), 64'h0);
        check("a_midrst_rd_q",   64'(a_rd_q),   64'h0);
        check("a_midrst_busy",   64'(a_busy),   64'h0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        a_drive(0, 0, 0, 0, 0, 1, 2, 3);
        a_exp_q.push_back(32'h0);
        a_drive(0, 0, 0, 0, 0, 0, 0, 0);

        // Wide instance: fill every register, then read mirrored pairs
        for (int k = 0; k < 16; k++) begin
            b_drive(1, k, k * 'h01010101, 0, 0, 0, 0, 0);
        end
        for (int k = 0; k < 16; k++) begin
            b_drive(0, 0, 0, 0, 0, 1, k, 15 - k);
            b_exp_q.push_back({32'(k * 'h01010101), 32'((15 - k) * 'h01010101)});
            @(negedge clk);
            check("b_sweep_ready", 64'(b_rd_ready), 64'h1);
        end

        // r0 is hard zero: write and lock are ignored, bypass is overridden
        b_drive(1, 0, 'hFFFF, 1, 0, 0, 0, 0);
        b_drive(0, 0, 0, 0, 0, 1, 0, 0);
        b_exp_q.push_back(64'h0);
        @(negedge clk);
        check("b_r0_ready", 64'(b_rd_ready), 64'h1);
        check("b_r0_busy",  64'(b_busy),     64'h0);
        b_drive(1, 0, 'hFFFFFFFF, 0, 0, 1, 0, 15);
        b_exp_q.push_back({32'h0, 32'h0F0F0F0F});
        b_drive(0, 0, 0, 0, 0, 0, 0, 0);

        repeat (3) @(negedge clk);
        check("a_queue_drained", 64'(a_exp_q.size()), 64'h0);
        check("b_queue_drained", 64'(b_exp_q.size()), 64'h0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
